// File: rtl/shared_bus_if.sv
// Handshake/bus bundle between bus sources (master) and the arbiter (slave).
// owner_id is clog2(N) bits wide, with a floor of one bit.
interface shared_bus_if #(
  parameter int N  = 4,
  parameter int DW = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   bus_data;
  logic            bus_valid;
  logic [IW-1:0]   owner_id;
  logic            timeout_pulse;

  modport master (
    output req, data_in,
    input  gnt, bus_data, bus_valid, owner_id, timeout_pulse
  );

  modport slave (
    input  req, data_in,
    output gnt, bus_data, bus_valid, owner_id, timeout_pulse
  );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner select for a shared wired-OR bus, with a one-cycle turnaround gap and a hold limit.
// Optional macro ARB_STATS_EN adds a saturating 16-bit grant_count output.
module shared_bus_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  shared_bus_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] grant_count
`endif
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIMIT = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

  state_t        state_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] ptr_q;
  logic [HW-1:0] hold_q;
  logic          timeout_q;

  logic          win_found_d;
  logic [IW-1:0] win_idx_d;
  logic [IW-1:0] ptr_d;
  logic [DW-1:0] bus_data_d;

  // First requester at or above the pointer, wrapping past N-1.
  // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found_d && bus.req[(int'(ptr_q) + k) % N]) begin
        win_found_d = 1'b1;
        win_idx_d   = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  assign ptr_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

  // NOTE: state and outputs use non-blocking '<=' and an asynchronous reset, so rst clears gnt without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        GRANT: begin
          if (!bus.req[owner_q]) begin
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= HANDOVER;
          end else if (MAX_HOLD != 0 && hold_q == HOLD_LIMIT) begin
            gnt_q     <= '0;
            ptr_q     <= ptr_d;
            timeout_q <= 1'b1;
            state_q   <= HANDOVER;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          if (win_found_d) begin
            gnt_q   <= N'(1) << win_idx_d;
            owner_q <= win_idx_d;
            hold_q  <= '0;
            state_q <= GRANT;
          end else begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // gnt is one-hot, so OR-ing the masked slices models the wired bus; idle level is 0.
  always_comb begin
    bus_data_d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) bus_data_d = bus_data_d | bus.data_in[i*DW +: DW];
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.bus_valid     = |gnt_q;
  assign bus.bus_data      = bus_data_d;
  assign bus.owner_id      = owner_q;
  assign bus.timeout_pulse = timeout_q;

`ifdef ARB_STATS_EN
  logic [15:0] grant_count_q;
  logic        new_grant_d;

  assign new_grant_d = (state_q != GRANT) && win_found_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_count_q <= '0;
    end else if (new_grant_d && grant_count_q != 16'hFFFF) begin
      grant_count_q <= grant_count_q + 16'd1;
    end
  end

  assign grant_count = grant_count_q;
`endif
endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed self-checking bench for shared_bus_arbiter (N=4, DW=4, MAX_HOLD=8).
// With ARB_STATS_EN defined it also checks grant_count counting and saturation.
module tb_shared_bus_arbiter;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  shared_bus_if #(.N(4), .DW(4)) bus_if ();

`ifdef ARB_STATS_EN
  logic [15:0] grant_count;
`endif

  shared_bus_arbiter #(.N(4), .DW(4), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [3:0] g, input logic v,
                           input logic [3:0] d, input logic [1:0] o, input logic p);
    check({tag, ".gnt"},       32'(bus_if.gnt),           32'(g));
    check({tag, ".valid"},     32'(bus_if.bus_valid),     32'(v));
    check({tag, ".data"},      32'(bus_if.bus_data),      32'(d));
    check({tag, ".owner"},     32'(bus_if.owner_id),      32'(o));
    check({tag, ".timeout"},   32'(bus_if.timeout_pulse), 32'(p));
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus_if.req     = 4'b1111;
    bus_if.data_in = 16'h4321;

    // Held in reset with every source requesting.
    repeat (5) begin
      step();
      check_bus("reset", 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);
    end

    // All sources requesting: each owner held 8 cycles, then a gap carrying the timeout pulse.
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        check_bus($sformatf("rr_k%0d_c%0d", k, c), 4'(1 << k), 1'b1, 4'(k + 1), 2'(k), 1'b0);
        step();
      end
      check_bus($sformatf("rr_gap%0d", k), 4'b0000, 1'b0, 4'h0, 2'(k), 1'b1);
      step();
    end
    check_bus("rr_wrap", 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0);

    // Voluntary release: gap without a pulse, then idle.
    bus_if.req = 4'b0000;
    step();
    check_bus("rel_gap", 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);
    step();
    check_bus("rel_idle", 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);

    // Source 1 alone for three sampled cycles with data 4'hA.
    bus_if.data_in = 16'h43A1;
    bus_if.req     = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step();
      check_bus($sformatf("src1_c%0d", c), 4'b0010, 1'b1, 4'hA, 2'd1, 1'b0);
    end
    bus_if.data_in = 16'h4351;
    #1;
    check("src1_passthru", 32'(bus_if.bus_data), 32'h5);
    bus_if.req = 4'b0000;
    step();
    check_bus("src1_gap", 4'b0000, 1'b0, 4'h0, 2'd1, 1'b0);
    step();
    check_bus("src1_idle", 4'b0000, 1'b0, 4'h0, 2'd1, 1'b0);

    // Source 2 alone for a long time: two revocations, then a release on hold cycle 8.
    bus_if.data_in = 16'h4321;
    bus_if.req     = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        check_bus($sformatf("src2_r%0d_c%0d", r, c), 4'b0100, 1'b1, 4'h3, 2'd2, 1'b0);
      end
      step();
      check_bus($sformatf("src2_gap%0d", r), 4'b0000, 1'b0, 4'h0, 2'd2, 1'b1);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      check_bus($sformatf("src2_last_c%0d", c), 4'b0100, 1'b1, 4'h3, 2'd2, 1'b0);
    end
    bus_if.req = 4'b0000;
    step();
    check_bus("src2_drop_at_limit", 4'b0000, 1'b0, 4'h0, 2'd2, 1'b0);
    step();
    check_bus("src2_idle", 4'b0000, 1'b0, 4'h0, 2'd2, 1'b0);

    // A request pulse that does not span a rising edge is ignored.
    bus_if.req = 4'b0001;
    #2;
    bus_if.req = 4'b0000;
    step();
    check_bus("glitch", 4'b0000, 1'b0, 4'h0, 2'd2, 1'b0);

    // Asynchronous reset between edges mid-grant; pointer restarts at 0.
    bus_if.req = 4'b1000;
    step();
    check_bus("src3", 4'b1000, 1'b1, 4'h4, 2'd3, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_bus("async_rst", 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);
    bus_if.req = 4'b1010;
    step();
    check_bus("async_rst_hold", 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    check_bus("post_rst", 4'b0010, 1'b1, 4'h2, 2'd1, 1'b0);

`ifdef ARB_STATS_EN
    // Five single-source grants since reset (post_rst was the first).
    bus_if.req = 4'b0000;
    step();
    step();
    for (int s = 0; s < 4; s++) begin
      bus_if.req = (s == 1) ? 4'b0100 : (s == 2) ? 4'b1000 : 4'b0001;
      step();
      bus_if.req = 4'b0000;
      step();
      step();
    end
    check("grant_count_5", 32'(grant_count), 32'd5);

    force dut.grant_count_q = 16'hFFFE;
    #1;
    release dut.grant_count_q;
    bus_if.req = 4'b0001;
    step();
    check("grant_count_ffff", 32'(grant_count), 32'hFFFF);
    bus_if.req = 4'b0000;
    step();
    step();
    bus_if.req = 4'b0010;
    step();
    check("grant_count_sat", 32'(grant_count), 32'hFFFF);
    bus_if.req = 4'b0000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Round-robin arbiter and driver-select for a shared wired bus that several sources want to drive.
- Sits directly upstream of the wire-resolution stage and guarantees exactly one source drives the bus at a time.
- Inserts a one-cycle turnaround gap between owners, so no two drivers ever overlap on the wire.

Parameters:
- N, 4, number of requesters (N >= 2).
- DW, 4, bus data width in bits.
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; 0 = unlimited hold.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-source bus request; bit i belongs to source i.
- data_in  input  N*DW  source i data on bits [i*DW +: DW].
- gnt  output  N  registered one-hot grant; all zero when no owner.
- bus_data  output  DW  resolved bus value.
- bus_valid  output  1  high while any grant is active.
- owner_id  output  clog2(N)  index of the current or most recent owner.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- One clock domain. Reset is asynchronous and active-high; the ports are named clk and rst.
- Reset value of every output and register is 0. This covers gnt, bus_data, bus_valid, owner_id, timeout_pulse, the hold counter and the round-robin pointer.
- Reset takes effect immediately on rst assertion, mid-grant included. Grant and bus outputs must not wait for a clock edge.
- States:
  - IDLE: no owner.
  - GRANT: one owner.
  - HANDOVER: one forced gap cycle.
- Arbitration, evaluated in IDLE and HANDOVER:
  - Select the first set req bit at or after the pointer, searching upward and wrapping from N-1 to 0.
  - If one is found, next cycle: gnt becomes one-hot of the winner, owner_id takes the winner, hold counter = 0, state GRANT.
  - If none is found, state IDLE and gnt stays 0.
- Latency: req sampled at edge t gives gnt from edge t, visible in cycle t+1.
- GRANT:
  - The hold counter increments every cycle.
  - If req[owner] is sampled low: gnt cleared, pointer = (owner+1) mod N, state HANDOVER, no timeout_pulse.
  - Otherwise, if MAX_HOLD != 0 and hold counter == MAX_HOLD-1: gnt cleared, timeout_pulse = 1 for exactly one cycle, pointer = (owner+1) mod N, state HANDOVER.
  - Owner drops req in the same cycle the limit is reached: this is a normal release, with no timeout_pulse.
  - gnt is therefore high for at most MAX_HOLD consecutive cycles.
- HANDOVER:
  - Lasts exactly one cycle with gnt = 0, then arbitrates as IDLE does.
  - The minimum gap between any two grants is 1 cycle, even when the same source regains the bus.
- Bus outputs, combinational from registered gnt:
  - bus_valid = OR of gnt.
  - bus_data = data_in slice of the granted source when bus_valid, else 0 (wired-OR idle level).
  - Zero latency from gnt; data_in changes pass straight through during a grant.
- owner_id holds its value after release until the next grant.
- A req pulse shorter than one clock that is not sampled high at an edge is ignored.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output port grant_count (16 bits, reset 0).
  - Increments by 1 on every edge that issues a new grant, including a re-grant to the same source after HANDOVER.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- rst=1 with req=4'b1111 for 5 cycles → gnt=0, bus_valid=0, bus_data=0 throughout. Release rst → first gnt=4'b0001, owner_id=0.
- req=4'b0010 held 3 cycles, data_in[7:4]=4'hA → gnt=4'b0010 from the next cycle for 3 cycles, bus_data=4'hA, bus_valid=1. Then 1 cycle gnt=0, then IDLE.
- req=4'b1111 constant, MAX_HOLD=8 → gnt 0001 ×8, 0000 ×1, 0010 ×8, 0000, 0100, 0000, 1000, 0000, 0001. timeout_pulse fires once per revocation.
- Only req[2] set, held 20 cycles, MAX_HOLD=8 → gnt[2] high 8 cycles, 1 gap cycle, high 8 cycles, gap, then regrant, with 2 timeout_pulses. Drop req[2] in hold cycle 8 → no pulse.
- Assert rst asynchronously mid-grant, between edges → gnt, bus_valid and bus_data go to 0 before the next edge. After release, arbitration restarts at index 0.
- ARB_STATS_EN defined: five separate single-source requests → grant_count=5. Force 65540 grants, or preload via force → grant_count stays 16'hFFFF.
